// File: rtl/axistream_packet_gate.sv
// axistream_packet_gate: credit-metered AXI-Stream gate; each credit releases one whole packet.
// Define AXISTREAM_PACKET_GATE_DROP_EN to add the flush port and the whole-packet DROP state.
module axistream_packet_gate #(
    parameter int DATA_WIDTH   = 8,
    parameter int CREDIT_WIDTH = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src_tvalid,
    output logic                    src_tready,
    input  logic [DATA_WIDTH-1:0]   src_tdata,
    input  logic                    src_tlast,
    output logic                    dest_tvalid,
    input  logic                    dest_tready,
    output logic [DATA_WIDTH-1:0]   dest_tdata,
    output logic                    dest_tlast,
    input  logic                    go,
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
    input  logic                    flush,
`endif
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    credit_overflow,
    output logic [COUNT_WIDTH-1:0]  pkt_count,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PASS = 2'd1;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
    localparam logic [1:0] DROP = 2'd2;
`endif
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = '1;

    logic [1:0]              state;
    logic [1:0]              state_next;
    logic                    in_pass;
    logic                    pass_done;
    logic                    select;
    logic                    credit_dec;
    logic                    credit_inc;
    logic [CREDIT_WIDTH-1:0] credits_next;

    assign in_pass    = (state == PASS);
    assign dest_tdata = src_tdata;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;
    assign pass_done  = in_pass && src_tvalid && dest_tready && src_tlast;

    // A beat transfers on valid && ready of its side; in PASS the two sides are wired
    // straight through, so a source beat moves exactly when the consumer takes it.
    assign dest_tvalid = rst_n && in_pass && src_tvalid;
    assign dest_tlast  = rst_n && in_pass && src_tlast;

`ifdef AXISTREAM_PACKET_GATE_DROP_EN
    logic in_drop;
    logic drop_done;
    logic drop_pending;
    logic take_drop;

    assign in_drop    = (state == DROP);
    assign drop_done  = in_drop && src_tvalid && src_tlast;
    assign select     = (state == IDLE) || pass_done || drop_done;
    assign src_tready = rst_n && (in_pass ? dest_tready : in_drop);
`else
    assign select     = (state == IDLE) || pass_done;
    assign src_tready = rst_n && in_pass && dest_tready;
`endif

    // Packet boundary: a pending drop wins over a credit; otherwise spend a credit
    // on the same edge so consecutive packets flow without a bubble.
    always_comb begin
        state_next = state;
        credit_dec = 1'b0;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
        take_drop  = 1'b0;
`endif
        if (select) begin
            state_next = IDLE;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
            if (drop_pending) begin
                state_next = DROP;
                take_drop  = 1'b1;
            end else
`endif
            if (credits != '0) begin
                state_next = PASS;
                credit_dec = 1'b1;
            end
        end
    end

    // A decrement frees a slot first, so go at saturation still lands when a credit is spent.
    assign credit_inc   = go && ((credits != CREDIT_MAX) || credit_dec);
    assign credits_next = credits + CREDIT_WIDTH'(credit_inc) - CREDIT_WIDTH'(credit_dec);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            credits         <= '0;
            credit_overflow <= 1'b0;
            pkt_count       <= '0;
        end else begin
            state           <= state_next;
            credits         <= credits_next;
            credit_overflow <= go && (credits == CREDIT_MAX) && !credit_dec;
            if (pass_done) begin
                pkt_count <= pkt_count + COUNT_WIDTH'(1);
            end
        end
    end

`ifdef AXISTREAM_PACKET_GATE_DROP_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_pending <= 1'b0;
        end else begin
            drop_pending <= (drop_pending && !take_drop) || flush;
        end
    end
`endif

endmodule

// File: tb/tb_axistream_packet_gate.sv
// Bench for axistream_packet_gate: directed scenarios plus random traffic against a packet-level model.
// Drop scenarios are exercised only when AXISTREAM_PACKET_GATE_DROP_EN is defined.
module tb_axistream_packet_gate;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int NW   = 16;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          src_tvalid;
    logic          src_tready;
    logic [DW-1:0] src_tdata;
    logic          src_tlast;
    logic          dest_tvalid;
    logic          dest_tready;
    logic [DW-1:0] dest_tdata;
    logic          dest_tlast;
    logic          go;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
    logic          flush;
`endif
    logic [CW-1:0] credits;
    logic          credit_overflow;
    logic [NW-1:0] pkt_count;
    logic          busy;
    logic [1:0]    dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    axistream_packet_gate #(
        .DATA_WIDTH  (DW),
        .CREDIT_WIDTH(CW),
        .COUNT_WIDTH (NW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_tvalid     (src_tvalid),
        .src_tready     (src_tready),
        .src_tdata      (src_tdata),
        .src_tlast      (src_tlast),
        .dest_tvalid    (dest_tvalid),
        .dest_tready    (dest_tready),
        .dest_tdata     (dest_tdata),
        .dest_tlast     (dest_tlast),
        .go             (go),
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
        .flush          (flush),
`endif
        .credits        (credits),
        .credit_overflow(credit_overflow),
        .pkt_count      (pkt_count),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (packet-level) ----------------
    int m_credits  = 0;
    int m_pkt      = 0;
    bit m_open     = 0;   // a credit was spent and the current packet is flowing
    bit m_dropping = 0;   // current packet is being discarded
    bit m_pend     = 0;   // a flush is waiting for the next packet boundary
    bit m_ovf      = 0;

    // ---------------- source driver / scoreboard state ----------------
    logic [DW:0]   src_q[$];
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] obs_q[$];
    bit            rand_gaps = 0;
    int            cyc = 0;
    int            tv_count, first_tv_cyc, last_tv_cyc, tlast_count, ovf_count, acc_count;
    bit            last_tv, last_tready;

    task automatic clr_obs();
        tv_count     = 0;
        first_tv_cyc = -1;
        last_tv_cyc  = -1;
        tlast_count  = 0;
        ovf_count    = 0;
        acc_count    = 0;
        obs_q.delete();
    endtask

    task automatic refresh_src();
        if (!src_tvalid) begin
            src_tvalid = (src_q.size() > 0) && (!rand_gaps || $urandom_range(0, 3) != 0);
        end
        if (src_q.size() > 0) begin
            {src_tlast, src_tdata} = src_q[0];
        end else begin
            src_tlast = 1'b0;
            src_tdata = '0;
        end
    endtask

    task automatic push_pkt(input int len, input logic [DW-1:0] base);
        for (int i = 0; i < len; i++) begin
            src_q.push_back({(i == len - 1), base + DW'(i)});
        end
    endtask

    task automatic push_rand_pkt();
        int len;
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) begin
            src_q.push_back({(i == len - 1), DW'($urandom)});
        end
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, then drive after the rising edge.
    task automatic step();
        bit exp_tv, exp_tr, hs_src, sel, dec, take;
        @(negedge clk);
        exp_tv = rst_n && m_open && src_tvalid;
        exp_tr = rst_n && (m_open ? dest_tready : m_dropping);
        check("dest_tvalid", dest_tvalid, exp_tv);
        check("src_tready", src_tready, exp_tr);
        if (rst_n) check("dest_tlast", dest_tlast, m_open && src_tlast);
        check("dest_tdata", dest_tdata, src_tdata);
        check("credits", credits, m_credits);
        check("pkt_count", pkt_count, m_pkt);
        check("credit_overflow", credit_overflow, m_ovf);
        check("busy", busy, m_open || m_dropping);

        last_tv     = dest_tvalid;
        last_tready = src_tready;
        if (dest_tvalid) begin
            tv_count++;
            if (first_tv_cyc < 0) first_tv_cyc = cyc;
            last_tv_cyc = cyc;
            if (dest_tlast) tlast_count++;
        end
        if (credit_overflow) ovf_count++;
        if (src_tvalid && src_tready) acc_count++;

        if (exp_tv && dest_tready) exp_q.push_back({src_tlast, src_tdata});
        if (dest_tvalid && dest_tready) begin
            obs_q.push_back(dest_tdata);
            if (exp_q.size() == 0) check("sb_extra_beat", 1, 0);
            else check("sb_beat", {dest_tlast, dest_tdata}, exp_q.pop_front());
        end
        if (exp_q.size() != 0) begin
            check("sb_missing_beat", exp_q.size(), 0);
            exp_q.delete();
        end

        hs_src = src_tvalid && exp_tr;
        if (!rst_n) begin
            m_open = 0; m_dropping = 0; m_credits = 0; m_pkt = 0; m_pend = 0; m_ovf = 0;
        end else begin
            sel  = !m_open && !m_dropping;
            dec  = 0;
            take = 0;
            if (m_open && src_tvalid && dest_tready && src_tlast) begin
                m_pkt = (m_pkt + 1) % (1 << NW);
                sel   = 1;
            end
            if (m_dropping && src_tvalid && src_tlast) sel = 1;
            if (sel) begin
                m_open     = 0;
                m_dropping = 0;
                if (m_pend) begin
                    m_dropping = 1;
                    take       = 1;
                end else if (m_credits > 0) begin
                    m_open = 1;
                    dec    = 1;
                end
            end
            m_ovf = go && (m_credits == MAXC) && !dec;
            if (go && !m_ovf) m_credits++;
            if (dec) m_credits--;
            if (take) m_pend = 0;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
            if (flush) m_pend = 1;
`endif
        end

        @(posedge clk);
        #1;
        cyc++;
        go = 1'b0;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
        flush = 1'b0;
`endif
        if (hs_src) begin
            void'(src_q.pop_front());
            src_tvalid = 1'b0;
        end
        refresh_src();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        go          = 1'b0;
        dest_tready = 1'b0;
        rand_gaps   = 0;
        src_q.delete();
        src_tvalid  = 1'b0;
        refresh_src();
        step();
        step();
        rst_n = 1'b1;
    endtask

    int go_cyc;

    initial begin
        rst_n       = 1'b0;
        go          = 1'b0;
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
        flush       = 1'b0;
`endif
        dest_tready = 1'b0;
        src_tvalid  = 1'b0;
        src_tdata   = '0;
        src_tlast   = 1'b0;
        clr_obs();
        repeat (3) @(posedge clk);
        #1;

        // No credit: a packet is offered but never accepted.
        do_reset();
        check("reset_credits", credits, 0);
        check("reset_pkt_count", pkt_count, 0);
        check("reset_busy", busy, 0);
        dest_tready = 1'b1;
        push_pkt(3, 8'h10);
        refresh_src();
        clr_obs();
        repeat (10) step();
        check("t1_no_output", tv_count, 0);
        check("t1_no_accept", acc_count, 0);
        check("t1_credits", credits, 0);

        // One credit releases exactly one of two packets, two cycles after go.
        do_reset();
        dest_tready = 1'b1;
        push_pkt(4, 8'h20);
        push_pkt(4, 8'h30);
        refresh_src();
        clr_obs();
        go_cyc = cyc;
        go = 1'b1;
        step();
        repeat (14) step();
        check("t2_latency", first_tv_cyc - go_cyc, 2);
        check("t2_pkt_count", pkt_count, 1);
        check("t2_credits", credits, 0);
        check("t2_beats_out", tv_count, 4);
        check("t2_accepted", acc_count, 4);
        check("t2_second_held", src_tvalid && !src_tready, 1);

        // Three credits, three 2-beat packets: six contiguous output beats.
        do_reset();
        dest_tready = 1'b1;
        push_pkt(2, 8'h40);
        push_pkt(2, 8'h50);
        push_pkt(2, 8'h60);
        refresh_src();
        clr_obs();
        repeat (3) begin
            go = 1'b1;
            step();
        end
        repeat (10) step();
        check("t3_beats", tv_count, 6);
        check("t3_no_gap", last_tv_cyc - first_tv_cyc, 5);
        check("t3_pkt_count", pkt_count, 3);
        check("t3_credits", credits, 0);

        // Saturation while PASS waits for traffic, then go coinciding with the next PASS entry.
        do_reset();
        dest_tready = 1'b1;
        go = 1'b1;
        step();
        step();
        step();
        check("t4_waiting_busy", busy, 1);
        check("t4_waiting_credits", credits, 0);
        clr_obs();
        repeat (5) begin
            go = 1'b1;
            step();
        end
        step();
        step();
        check("t4_ovf_pulses", ovf_count, 2);
        check("t4_saturated", credits, MAXC);
        push_pkt(1, 8'h70);
        refresh_src();
        go = 1'b1;
        step();
        check("t4_credits_hold", credits, MAXC);
        check("t4_pkt_count", pkt_count, 1);
        check("t4_no_ovf", credit_overflow, 0);
        check("t4_busy", busy, 1);

`ifdef AXISTREAM_PACKET_GATE_DROP_EN
        // Flush discards packet A; the credit then passes packet B.
        do_reset();
        dest_tready = 1'b1;
        push_pkt(3, 8'hA1);
        push_pkt(2, 8'hB1);
        refresh_src();
        clr_obs();
        flush = 1'b1;
        go    = 1'b1;
        step();
        repeat (12) step();
        check("t5_pkt_count", pkt_count, 1);
        check("t5_accepted", acc_count, 5);
        check("t5_out_beats", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t5_first_b", obs_q[0], 8'hB1);
            check("t5_second_b", obs_q[1], 8'hB2);
        end
        check("t5_credits", credits, 0);
`endif

        // Reset during beat 2 truncates the packet with no tlast.
        do_reset();
        dest_tready = 1'b1;
        push_pkt(4, 8'hC0);
        refresh_src();
        clr_obs();
        go = 1'b1;
        step();
        step();
        step();
        check("t6_beat1_out", last_tv, 1);
        rst_n = 1'b0;
        step();
        check("t6_rst_tvalid", last_tv, 0);
        check("t6_rst_tready", last_tready, 0);
        rst_n = 1'b1;
        repeat (8) step();
        check("t6_credits", credits, 0);
        check("t6_pkt_count", pkt_count, 0);
        check("t6_busy", busy, 0);
        check("t6_no_tlast", tlast_count, 0);
        check("t6_beats_out", tv_count, 1);

        // Random traffic, credits, back-pressure and occasional resets.
        do_reset();
        rand_gaps = 1;
        clr_obs();
        repeat (1500) begin
            if (src_q.size() < 2) push_rand_pkt();
            go          = ($urandom_range(0, 5) == 0);
`ifdef AXISTREAM_PACKET_GATE_DROP_EN
            flush       = ($urandom_range(0, 24) == 0);
`endif
            dest_tready = ($urandom_range(0, 3) != 0);
            rst_n       = ($urandom_range(0, 299) != 0);
            refresh_src();
            step();
        end
        rst_n = 1'b1;
        check("t7_traffic_seen", tv_count > 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
